mac_preadd_accum_stream: RTL and testbench

//  Pipelined, stream-handshaked pre-add MAC: per beat computes (a+b)*(c+d), then either emits

---
 rtl/mac_preadd_accum_stream_pkg.sv | 18 +
 rtl/mac_preadd_accum_stream_if.sv | 31 +++
 rtl/mac_preadd_accum_stream_mul.sv | 63 ++++++
 rtl/mac_preadd_accum_stream.sv | 128 ++++++++++++
 tb/tb_mac_preadd_accum_stream.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_preadd_accum_stream_pkg.sv
// Shared width helpers and pipeline constants for the pre-add MAC stream.
package mac_pkg;

  localparam int MAC_LATENCY = 3;

  function automatic int preadd_w(input int data_width);
    return data_width + 1;
  endfunction

  function automatic int prod_w(input int data_width);
    return 2 * data_width + 2;
  endfunction

  function automatic bit acc_width_ok(input int data_width, input int acc_width);
    return acc_width >= prod_w(data_width);
  endfunction

endpackage

// File: rtl/mac_preadd_accum_stream_if.sv
// Stream bundle for the pre-add MAC: operand input side and result output side.
interface mac_stream_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int CNT_WIDTH  = 16
);
  logic                  accum_en;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] a_data;
  logic [DATA_WIDTH-1:0] b_data;
  logic [DATA_WIDTH-1:0] c_data;
  logic [DATA_WIDTH-1:0] d_data;
  logic                  s_last;
  logic                  m_valid;
  logic                  m_ready;
  logic [ACC_WIDTH-1:0]  m_data;
  logic                  m_last;
  logic [CNT_WIDTH-1:0]  m_beats;
  logic                  m_ovf;

  modport slave (
    input  accum_en, s_valid, a_data, b_data, c_data, d_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last, m_beats, m_ovf
  );

  modport master (
    output accum_en, s_valid, a_data, b_data, c_data, d_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last, m_beats, m_ovf
  );
endinterface

// File: rtl/mac_preadd_accum_stream_mul.sv
// Stages 1 and 2 of the MAC: full-width pre-adders then the product, with sideband.
module mac_preadd_mul
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic                               en,
  input  logic                               valid,
  input  logic                               last,
  input  logic                               mode,
  input  logic [DATA_WIDTH-1:0]              a,
  input  logic [DATA_WIDTH-1:0]              b,
  input  logic [DATA_WIDTH-1:0]              c,
  input  logic [DATA_WIDTH-1:0]              d,
  output logic                               prod_valid,
  output logic                               prod_last,
  output logic                               prod_mode,
  output logic [prod_w(DATA_WIDTH)-1:0]      prod
);

  localparam int PW = preadd_w(DATA_WIDTH);
  localparam int MW = prod_w(DATA_WIDTH);

  logic          s1_valid;
  logic          s1_last;
  logic          s1_mode;
  logic [PW-1:0] sum_ab;
  logic [PW-1:0] sum_cd;

  // Pre-adders keep the carry bit so all-ones operands are not truncated
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_mode  <= 1'b0;
      sum_ab   <= '0;
      sum_cd   <= '0;
    end else if (en) begin
      s1_valid <= valid;
      s1_last  <= last;
      s1_mode  <= mode;
      sum_ab   <= PW'(a) + PW'(b);
      sum_cd   <= PW'(c) + PW'(d);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      prod_valid <= 1'b0;
      prod_last  <= 1'b0;
      prod_mode  <= 1'b0;
      prod       <= '0;
    end else if (en) begin
      prod_valid <= s1_valid;
      prod_last  <= s1_last;
      prod_mode  <= s1_mode;
      prod       <= MW'(sum_ab) * MW'(sum_cd);
    end
  end

endmodule

// File: rtl/mac_preadd_accum_stream.sv
// Pre-add MAC with per-beat or per-frame accumulation and a single global stall enable.
// Optional macro MAC_ACC_SAT_EN: saturate the accumulator and report m_ovf per frame.
module mac_preadd_accum_stream
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int CNT_WIDTH  = 16
) (
  input logic         aclk,
  input logic         aresetn,
  mac_stream_if.slave bus
);

  localparam int  MW           = prod_w(DATA_WIDTH);
  localparam bit  ACC_WIDTH_OK = acc_width_ok(DATA_WIDTH, ACC_WIDTH);

  if (!ACC_WIDTH_OK) begin : g_acc_width_check
    $error("ACC_WIDTH must be at least 2*DATA_WIDTH+2");
  end

  logic                 en;
  logic                 prod_valid;
  logic                 prod_last;
  logic                 prod_mode;
  logic [MW-1:0]        prod;
  logic [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] total;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 ovf_next;
  logic                 close_frame;
  logic                 out_valid;
  logic [ACC_WIDTH-1:0] out_data;
  logic                 out_last;
  logic [CNT_WIDTH-1:0] out_beats;
  logic                 out_ovf;

  // Every stage moves together whenever the output register can take a new value
  assign en          = !out_valid || bus.m_ready;
  assign bus.s_ready = aresetn && en;

  mac_preadd_mul #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_preadd_mul (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .en         (en),
    .valid      (bus.s_valid),
    .last       (bus.s_last),
    .mode       (bus.accum_en),
    .a          (bus.a_data),
    .b          (bus.b_data),
    .c          (bus.c_data),
    .d          (bus.d_data),
    .prod_valid (prod_valid),
    .prod_last  (prod_last),
    .prod_mode  (prod_mode),
    .prod       (prod)
  );

  assign close_frame = !prod_mode || prod_last;

`ifdef MAC_ACC_SAT_EN
  logic [ACC_WIDTH:0] raw_sum;
  logic               acc_ovf;

  always_comb begin
    prod_ext = ACC_WIDTH'(prod);
    raw_sum  = {1'b0, acc} + {1'b0, prod_ext};
    total    = raw_sum[ACC_WIDTH] ? '1 : raw_sum[ACC_WIDTH-1:0];
    ovf_next = acc_ovf || raw_sum[ACC_WIDTH];
    cnt_next = (&cnt) ? cnt : cnt + CNT_WIDTH'(1);
  end

  // Overflow is sticky for the open frame and cleared whenever a frame closes
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      acc_ovf <= 1'b0;
    end else if (en && prod_valid) begin
      acc_ovf <= close_frame ? 1'b0 : ovf_next;
    end
  end
`else
  always_comb begin
    prod_ext = ACC_WIDTH'(prod);
    total    = acc + prod_ext;
    ovf_next = 1'b0;
    cnt_next = (&cnt) ? cnt : cnt + CNT_WIDTH'(1);
  end
`endif

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_beats <= '0;
      out_ovf   <= 1'b0;
    end else if (en) begin
      if (prod_valid && close_frame) begin
        out_valid <= 1'b1;
        out_last  <= 1'b1;
        out_data  <= total;
        out_beats <= cnt_next;
        out_ovf   <= ovf_next;
        acc       <= '0;
        cnt       <= '0;
      end else if (prod_valid) begin
        acc       <= total;
        cnt       <= cnt_next;
        out_valid <= 1'b0;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.m_valid = out_valid;
  assign bus.m_data  = out_data;
  assign bus.m_last  = out_last;
  assign bus.m_beats = out_beats;
  assign bus.m_ovf   = out_ovf;

endmodule

// File: tb/tb_mac_preadd_accum_stream.sv
// Self-checking bench: vector table, multi-cycle corner sequences and a random stream
// compared against a frame-level arithmetic model; adapts to MAC_ACC_SAT_EN.
module tb_mac_preadd_accum_stream;
  import mac_pkg::*;

  localparam int DW = 16;
  localparam int AW = 36;
  localparam int CW = 4;
  localparam longint unsigned ACC_MAX = (64'd1 << AW) - 64'd1;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct {
    logic [AW-1:0] data;
    logic [CW-1:0] beats;
    logic          ovf;
  } result_t;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
    logic [DW-1:0] d;
    logic [AW-1:0] exp_data;
  } vec_t;

  logic aclk;
  logic aresetn;
  int   errors = 0;
  int   checks = 0;

  mac_stream_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  mac_preadd_accum_stream #(
    .DATA_WIDTH (DW),
    .ACC_WIDTH  (AW),
    .CNT_WIDTH  (CW)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  result_t         exp_q[$];
  longint unsigned frame_sum = 0;
  int              frame_beats = 0;
  int              out_count = 0;
  result_t         last_out;
  logic            stall_seen = 1'b0;
  result_t         held;
  logic            rand_ready = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  function automatic result_t closeFrame(input longint unsigned sum, input int beats);
    result_t r;
`ifdef MAC_ACC_SAT_EN
    r.data = (sum > ACC_MAX) ? AW'(ACC_MAX) : AW'(sum);
    r.ovf  = (sum > ACC_MAX);
`else
    r.data = AW'(sum);
    r.ovf  = 1'b0;
`endif
    r.beats = (beats > CNT_MAX) ? CW'(CNT_MAX) : CW'(beats);
    return r;
  endfunction

  // Reference model: frame arithmetic on every accepted input beat
  always @(negedge aclk) begin
    if (!aresetn) begin
      frame_sum   = 0;
      frame_beats = 0;
      exp_q.delete();
    end else if (bus.s_valid && bus.s_ready) begin
      longint unsigned p;
      p = (longint'(bus.a_data) + longint'(bus.b_data)) * (longint'(bus.c_data) + longint'(bus.d_data));
      frame_sum   += p;
      frame_beats += 1;
      if (!bus.accum_en || bus.s_last) begin
        exp_q.push_back(closeFrame(frame_sum, frame_beats));
        frame_sum   = 0;
        frame_beats = 0;
      end
    end
  end

  // Output monitor: scoreboard compare and hold-stability under stall
  always @(negedge aclk) begin
    if (!aresetn) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen) begin
        checkOutput("hold_valid", 64'(bus.m_valid), 64'd1);
        checkOutput("hold_data", 64'(bus.m_data), 64'(held.data));
        checkOutput("hold_beats", 64'(bus.m_beats), 64'(held.beats));
        checkOutput("hold_ovf", 64'(bus.m_ovf), 64'(held.ovf));
      end
      stall_seen = 1'b0;
      if (bus.m_valid) begin
        if (bus.m_ready) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_out", 64'd1, 64'd0);
          end else begin
            result_t r;
            r = exp_q.pop_front();
            checkOutput("sb_data", 64'(bus.m_data), 64'(r.data));
            checkOutput("sb_beats", 64'(bus.m_beats), 64'(r.beats));
            checkOutput("sb_ovf", 64'(bus.m_ovf), 64'(r.ovf));
            checkOutput("sb_last", 64'(bus.m_last), 64'd1);
          end
          last_out.data  = bus.m_data;
          last_out.beats = bus.m_beats;
          last_out.ovf   = bus.m_ovf;
          out_count++;
        end else begin
          stall_seen = 1'b1;
          held.data  = bus.m_data;
          held.beats = bus.m_beats;
          held.ovf   = bus.m_ovf;
        end
      end
    end
  end

  always begin
    @(posedge aclk);
    #1;
    if (rand_ready) bus.m_ready = ($urandom_range(3) != 0);
  end

  task automatic applyStimulus(input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input logic [DW-1:0] c, input logic [DW-1:0] d,
                               input logic last, input logic mode);
    logic accepted;
    int   guard;
    bus.a_data   = a;
    bus.b_data   = b;
    bus.c_data   = c;
    bus.d_data   = d;
    bus.s_last   = last;
    bus.accum_en = mode;
    bus.s_valid  = 1'b1;
    guard = 0;
    accepted = 1'b0;
    while (!accepted && guard < 200) begin
      @(negedge aclk);
      accepted = bus.s_ready;
      @(posedge aclk);
      #1;
      guard++;
    end
    bus.s_valid = 1'b0;
    if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic waitOutputs(input int target);
    int guard = 0;
    while (out_count < target && guard < 200) begin
      @(posedge aclk);
      #1;
      guard++;
    end
    checkOutput("output_timeout", 64'(out_count >= target), 64'd1);
  endtask

  task automatic checkResetState();
    checkOutput("rst_m_valid", 64'(bus.m_valid), 64'd0);
    checkOutput("rst_s_ready", 64'(bus.s_ready), 64'd0);
    checkOutput("rst_m_data", 64'(bus.m_data), 64'd0);
    checkOutput("rst_m_beats", 64'(bus.m_beats), 64'd0);
    checkOutput("rst_m_last", 64'(bus.m_last), 64'd0);
    checkOutput("rst_m_ovf", 64'(bus.m_ovf), 64'd0);
  endtask

  initial begin
    vec_t vecs[7];
    int   n0;
    int   lat;
    logic [AW-1:0] exp6;
    logic          exp6_ovf;

    vecs[0] = '{a:16'd3,      b:16'd4,      c:16'd5,      d:16'd6,      exp_data:36'd77};
    vecs[1] = '{a:16'hFFFF,   b:16'hFFFF,   c:16'hFFFF,   d:16'hFFFF,   exp_data:36'h3_FFF8_0004};
    vecs[2] = '{a:16'd0,      b:16'd0,      c:16'd0,      d:16'd0,      exp_data:36'd0};
    vecs[3] = '{a:16'd2,      b:16'd0,      c:16'd3,      d:16'd0,      exp_data:36'd6};
    vecs[4] = '{a:16'hFFFF,   b:16'd1,      c:16'd0,      d:16'd0,      exp_data:36'd0};
    vecs[5] = '{a:16'hFFFF,   b:16'd1,      c:16'd1,      d:16'd0,      exp_data:36'h1_0000};
    vecs[6] = '{a:16'd100,    b:16'd200,    c:16'd7,      d:16'd9,      exp_data:36'd4800};

    aresetn      = 1'b0;
    bus.s_valid  = 1'b0;
    bus.s_last   = 1'b0;
    bus.accum_en = 1'b0;
    bus.a_data   = '0;
    bus.b_data   = '0;
    bus.c_data   = '0;
    bus.d_data   = '0;
    bus.m_ready  = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    checkResetState();
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // Single-beat vectors with latency check
    foreach (vecs[i]) begin
      n0 = out_count;
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, 1'b0, 1'b0);
      lat = 0;
      while (!bus.m_valid && lat < 20) begin
        @(posedge aclk);
        #1;
        lat++;
      end
      checkOutput("latency", 64'(lat), 64'(MAC_LATENCY - 1));
      waitOutputs(n0 + 1);
      checkOutput("vec_data", 64'(last_out.data), 64'(vecs[i].exp_data));
      checkOutput("vec_beats", 64'(last_out.beats), 64'd1);
    end

    // Four-beat accumulated frame of ones
    n0 = out_count;
    for (int i = 0; i < 4; i++) applyStimulus(16'd1, 16'd1, 16'd1, 16'd1, i == 3, 1'b1);
    waitOutputs(n0 + 1);
    checkOutput("frame4_data", 64'(last_out.data), 64'd16);
    checkOutput("frame4_beats", 64'(last_out.beats), 64'd4);
    checkOutput("frame4_count", 64'(out_count - n0), 64'd1);

    // Mode-0 beat closes an open accumulating frame
    n0 = out_count;
    applyStimulus(16'd1, 16'd0, 16'd1, 16'd0, 1'b0, 1'b1);
    applyStimulus(16'd2, 16'd0, 16'd5, 16'd0, 1'b0, 1'b0);
    waitOutputs(n0 + 1);
    checkOutput("close_data", 64'(last_out.data), 64'd11);
    checkOutput("close_beats", 64'(last_out.beats), 64'd2);

    // Continuous stream with a five-cycle downstream stall
    n0 = out_count;
    fork
      begin
        for (int i = 0; i < 12; i++)
          applyStimulus(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom), 1'b0, 1'b0);
      end
      begin
        repeat (5) @(posedge aclk);
        #1;
        bus.m_ready = 1'b0;
        @(posedge aclk);
        #1;
        checkOutput("stall_s_ready", 64'(bus.s_ready), 64'd0);
        checkOutput("stall_m_valid", 64'(bus.m_valid), 64'd1);
        repeat (4) @(posedge aclk);
        #1;
        bus.m_ready = 1'b1;
      end
    join
    waitOutputs(n0 + 12);
    checkOutput("stream_count", 64'(out_count - n0), 64'd12);

    // Reset in the middle of a frame discards it
    applyStimulus(16'd9, 16'd9, 16'd9, 16'd9, 1'b0, 1'b1);
    applyStimulus(16'd9, 16'd9, 16'd9, 16'd9, 1'b0, 1'b1);
    repeat (4) @(posedge aclk);
    #1;
    n0 = out_count;
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    checkResetState();
    aresetn = 1'b1;
    applyStimulus(16'd2, 16'd0, 16'd3, 16'd0, 1'b1, 1'b1);
    waitOutputs(n0 + 1);
    checkOutput("post_rst_data", 64'(last_out.data), 64'd6);
    checkOutput("post_rst_beats", 64'(last_out.beats), 64'd1);
    checkOutput("post_rst_count", 64'(out_count - n0), 64'd1);

    // Twenty all-ones beats: accumulator overflow and beat-count saturation
`ifdef MAC_ACC_SAT_EN
    exp6     = 36'hF_FFFF_FFFF;
    exp6_ovf = 1'b1;
`else
    exp6     = 36'hF_FF60_0050;
    exp6_ovf = 1'b0;
`endif
    n0 = out_count;
    for (int i = 0; i < 20; i++) applyStimulus(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, i == 19, 1'b1);
    waitOutputs(n0 + 1);
    checkOutput("big_data", 64'(last_out.data), 64'(exp6));
    checkOutput("big_ovf", 64'(last_out.ovf), 64'(exp6_ovf));
    checkOutput("big_beats", 64'(last_out.beats), 64'(CNT_MAX));

    // Ovf must not leak into the following frame
    n0 = out_count;
    applyStimulus(16'd1, 16'd0, 16'd1, 16'd0, 1'b1, 1'b1);
    waitOutputs(n0 + 1);
    checkOutput("ovf_cleared", 64'(last_out.ovf), 64'd0);

    // Randomised stream with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom),
                    $urandom_range(3) == 0, $urandom_range(2) != 0);
    end
    applyStimulus(16'd1, 16'd1, 16'd1, 16'd1, 1'b1, 1'b1);
    rand_ready = 1'b0;
    @(posedge aclk);
    #1;
    bus.m_ready = 1'b1;
    repeat (10) @(posedge aclk);
    #1;
    checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);
    checkOutput("drain_idle", 64'(bus.m_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule
